uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
//
// PURPOSE
//   Shares one uart_transmitter among NUM_REQ byte-stream requesters.
//   - Round-robin grant per message; the grant is held until the requester's
//     last byte or MAX_BURST bytes, so messages are not interleaved.
//   - Feeds the transmitter's write_enable/data inputs and throttles on its
//     buffer_full output.
//   - Owns the transmitter's baudrate_select and buffer_full_threshold.
//     Config changes take effect only between messages.
//
// PARAMETERS
//   NUM_REQ        4    number of requesters, 2..8
//   MAX_BURST      16   max bytes per grant before forced rotation, 1..64
//   RST_THRESHOLD  32   buffer_full_threshold value after reset, 6 bits
//   RST_BAUDRATE   0    baudrate_select value after reset, 2 bits
//
// PORTS
//   clock                     in   1            system clock, all logic on posedge
//   reset                     in   1            synchronous, active-low
//   req_valid                 in   NUM_REQ      requester i has a byte on req_data[i]
//   req_data                  in   NUM_REQ*8    byte of requester i at bits [8i+7:8i]
//   req_last                  in   NUM_REQ      req_data[i] is the last byte of the message
//   req_ready                 out  NUM_REQ      byte accepted when req_valid[i] & req_ready[i]
//   cfg_update                in   1            1-cycle pulse: capture cfg_* into shadow regs
//   cfg_baudrate_select       in   2            new baud select
//   cfg_threshold             in   6            new buffer-full threshold
//   cfg_pending               out  1            shadow captured, not yet applied
//   tx_write_enable           out  1            to transmitter write_enable
//   tx_data                   out  8            to transmitter data
//   tx_baudrate_select        out  2            to transmitter baudrate_select
//   tx_buffer_full_threshold  out  6            to transmitter buffer_full_threshold
//   tx_buffer_full            in   1            from transmitter buffer_full
//   grant_id                  out  clog2(NUM_REQ)  current or most recent grantee
//   busy                      out  1            1 while a grant is held (state LOCKED)
//
// BEHAVIOUR
//   Reset (reset==0 at posedge)
//   - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 wins first.
//   - tx_write_enable=0, tx_data=0, grant_id=0, busy=0, cfg_pending=0, req_ready=0.
//   - tx_baudrate_select=RST_BAUDRATE, tx_buffer_full_threshold=RST_THRESHOLD.
//   - Reset mid-message drops the message; there is no resume.
//
//   State IDLE
//   - If cfg_pending: copy shadow to tx_baudrate_select/threshold, clear cfg_pending.
//     No grant this cycle; config always wins over arbitration.
//   - Else if any req_valid: winner = first valid at index rr_ptr+1, rr_ptr+2, ...
//     (mod NUM_REQ). Then grant_id<=winner, burst_cnt<=0, state<=LOCKED.
//   - req_ready is all 0 in IDLE, so there is at least 1 cycle of grant latency.
//
//   State LOCKED (grantee g = grant_id)
//   - req_ready[g] = !tx_buffer_full (combinational). All other req_ready bits are 0.
//   - On a handshake of g: tx_data<=req_data[g], tx_write_enable<=1 (registered,
//     one-cycle pulse per byte), burst_cnt++.
//   - Back-to-back bytes are allowed: one byte per cycle.
//   - tx_buffer_full is sampled the same cycle as the handshake. At most one extra
//     write can therefore land after full asserts; threshold must leave 1 slot margin.
//   - Handshake with req_last[g]=1, or with burst_cnt==MAX_BURST-1:
//     rr_ptr<=g, state<=IDLE.
//   - req_valid[g] low: grant is held and the cycle idles. There is no timeout;
//     requesters must finish their message.
//   - tx_write_enable=0 on any cycle without a handshake.
//
//   Config
//   - cfg_update captures cfg_* into shadow and sets cfg_pending, in any state.
//   - A later cfg_update before apply overwrites the shadow (last wins).
//   - cfg_update in the same cycle as apply: the new value is captured and
//     cfg_pending stays 1.
//
//   Other outputs
//   - grant_id holds its value in IDLE.
//   - busy = (state==LOCKED).
//   - burst_cnt width is clog2(MAX_BURST)+1; it never wraps.
//
// TESTING
//   1. Single requester: req 2 sends 3 bytes {A5,5A,FF}, last on FF ->
//      tx_write_enable pulses 3 consecutive cycles, 1 cycle after each handshake;
//      busy falls after FF.
//   2. All 4 requesters valid after reset, 2-byte messages ->
//      grant order 0,1,2,3,0; bytes of different requesters never interleave.
//   3. Burst limit: MAX_BURST=16, req 1 streams 20 bytes, no last, req 3 waiting ->
//      16 bytes from req 1, then req 3 is granted, then req 1 resumes.
//   4. Backpressure: hold tx_buffer_full=1 for 10 cycles mid-message ->
//      req_ready[g]=0 and no write pulses; resumes on the first cycle after full falls.
//   5. Config: cfg_update (baud=2, thr=40) during a 5-byte message ->
//      tx_* unchanged until the message ends; applied in the first IDLE cycle;
//      next grant comes one cycle later.
//   6. Reset asserted mid-message for 3 cycles ->
//      all outputs at reset values, tx_baudrate_select=RST_BAUDRATE; requester 0 wins next.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundle between the requesters/config source/transmitter (master side) and
//   the uart_tx_arbiter (slave side).
//
//   Requester side : req_valid, req_data (byte i at [8i+7:8i]), req_last,
//                    req_ready
//   Config side    : cfg_update, cfg_baudrate_select, cfg_threshold,
//                    cfg_pending
//   Transmitter    : tx_write_enable, tx_data, tx_baudrate_select,
//                    tx_buffer_full_threshold, tx_buffer_full
//   Status         : grant_id, busy
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;

  logic                 cfg_update;
  logic [1:0]           cfg_baudrate_select;
  logic [5:0]           cfg_threshold;
  logic                 cfg_pending;

  logic                 tx_write_enable;
  logic [7:0]           tx_data;
  logic [1:0]           tx_baudrate_select;
  logic [5:0]           tx_buffer_full_threshold;
  logic                 tx_buffer_full;

  logic [IW-1:0]        grant_id;
  logic                 busy;

  // Drives requests/config/transmitter status, observes the arbiter.
  modport master (
    output req_valid, req_data, req_last,
    output cfg_update, cfg_baudrate_select, cfg_threshold,
    output tx_buffer_full,
    input  req_ready, cfg_pending,
    input  tx_write_enable, tx_data, tx_baudrate_select, tx_buffer_full_threshold,
    input  grant_id, busy
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, req_last,
    input  cfg_update, cfg_baudrate_select, cfg_threshold,
    input  tx_buffer_full,
    output req_ready, cfg_pending,
    output tx_write_enable, tx_data, tx_baudrate_select, tx_buffer_full_threshold,
    output grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter among NUM_REQ byte-stream requesters.
//   Round-robin grant per message; a grant is held until the grantee's last
//   byte or MAX_BURST bytes, so messages never interleave. Baud select and
//   buffer-full threshold are owned here and only change between messages.
//
//   Ports
//     i_clock : system clock, all logic on posedge
//     i_reset : synchronous, active-low
//     bus     : uart_tx_arbiter_if.slave (requesters, config, transmitter,
//               grant_id/busy status)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int RST_THRESHOLD = 32,
  parameter int RST_BAUDRATE  = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  uart_tx_arbiter_if.slave  bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t        r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_grant;
  logic [BW-1:0] r_burst;
  logic          r_we;
  logic [7:0]    r_data;
  logic [1:0]    r_baud;
  logic [5:0]    r_thr;
  logic [1:0]    r_sh_baud;
  logic [5:0]    r_sh_thr;
  logic          r_pending;

  logic               w_found;
  logic [IW-1:0]      w_winner;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_hs;
  logic               w_last;
  logic [7:0]         w_byte;

  // Round-robin search starting just after the previous grantee.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_found && bus.req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = IW'(idx);
      end
    end
  end

  // Only the grantee sees ready, and only while the transmitter has room.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ready
    assign w_ready[g] = (r_state == LOCKED) && !bus.tx_buffer_full &&
                        (r_grant == IW'(g));
  end

  assign w_hs   = w_ready[r_grant] & bus.req_valid[r_grant];
  assign w_last = bus.req_last[r_grant];
  assign w_byte = bus.req_data[int'(r_grant)*8 +: 8];

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state   <= IDLE;
      r_rr_ptr  <= IW'(NUM_REQ - 1);
      r_grant   <= '0;
      r_burst   <= '0;
      r_we      <= 1'b0;
      r_data    <= '0;
      r_baud    <= 2'(RST_BAUDRATE);
      r_thr     <= 6'(RST_THRESHOLD);
      r_sh_baud <= 2'(RST_BAUDRATE);
      r_sh_thr  <= 6'(RST_THRESHOLD);
      r_pending <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // Pending config is applied before any new grant.
          if (r_pending) begin
            r_baud    <= r_sh_baud;
            r_thr     <= r_sh_thr;
            r_pending <= 1'b0;
          end else if (w_found) begin
            r_grant <= w_winner;
            r_burst <= '0;
            r_state <= LOCKED;
          end
        end
        LOCKED: begin
          if (w_hs) begin
            r_data  <= w_byte;
            r_we    <= 1'b1;
            r_burst <= r_burst + 1'b1;
            if (w_last || (r_burst == BW'(MAX_BURST - 1))) begin
              r_rr_ptr <= r_grant;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // Placed after the case so a capture coinciding with apply keeps pending set.
      if (bus.cfg_update) begin
        r_sh_baud <= bus.cfg_baudrate_select;
        r_sh_thr  <= bus.cfg_threshold;
        r_pending <= 1'b1;
      end
    end
  end

  assign bus.req_ready                = w_ready;
  assign bus.cfg_pending              = r_pending;
  assign bus.tx_write_enable          = r_we;
  assign bus.tx_data                  = r_data;
  assign bus.tx_baudrate_select       = r_baud;
  assign bus.tx_buffer_full_threshold = r_thr;
  assign bus.grant_id                 = r_grant;
  assign bus.busy                     = (r_state == LOCKED);
endmodule
